// File: rtl/reg_file_multiport_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_multiport_pkg
//   Shared definitions for the multi-port register file slice.
//   - DATA_WIDTH / ADDR_WIDTH / DEPTH : default geometry (32 x 32-bit)
//   - reg_index_t                     : register index at the default width
//   - read_src_t                      : which source a read port returns
//   - read_mux()                      : zero / bypass / storage priority
// ---------------------------------------------------------------------------
package reg_file_multiport_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_index_t;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_WRITE1 = 2'd1,
    SRC_WRITE2 = 2'd2,
    SRC_STORE  = 2'd3
  } read_src_t;

  // The priority is expressed as a source select rather than a data mux so
  // the same function serves any DATA_WIDTH the top is built with.
  function automatic read_src_t read_mux(input logic zero_hit,
                                         input logic wr1_hit,
                                         input logic wr2_hit);
    read_src_t src;
    if (zero_hit)      src = SRC_ZERO;
    else if (wr1_hit)  src = SRC_WRITE1;
    else if (wr2_hit)  src = SRC_WRITE2;
    else               src = SRC_STORE;
    return src;
  endfunction

endpackage

// File: rtl/reg_file_multiport_if.sv
// ---------------------------------------------------------------------------
// reg_file_multiport_if
//   Bundles the read, write, reserve and status signals of the register file.
//   master : decode / write-back side (drives indices, writes, reserves)
//   slave  : the register file (drives read values, busy bits, collision)
// ---------------------------------------------------------------------------
interface reg_file_multiport_if #(
  parameter int DATA_WIDTH = reg_file_multiport_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_multiport_pkg::ADDR_WIDTH
);
  import reg_file_multiport_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] read_index1;
  logic [DATA_WIDTH-1:0] read_value1;
  logic [ADDR_WIDTH-1:0] read_index2;
  logic [DATA_WIDTH-1:0] read_value2;
  logic                  write1;
  logic [ADDR_WIDTH-1:0] write_index1;
  logic [DATA_WIDTH-1:0] write_data1;
  logic                  write2;
  logic [ADDR_WIDTH-1:0] write_index2;
  logic [DATA_WIDTH-1:0] write_data2;
  logic                  reserve;
  logic [ADDR_WIDTH-1:0] reserve_index;
  logic                  busy1;
  logic                  busy2;
  logic [DEPTH-1:0]      busy_mask;
  logic                  collision;

  modport master (
    output read_index1, read_index2,
    output write1, write_index1, write_data1,
    output write2, write_index2, write_data2,
    output reserve, reserve_index,
    input  read_value1, read_value2,
    input  busy1, busy2, busy_mask, collision
  );

  modport slave (
    input  read_index1, read_index2,
    input  write1, write_index1, write_data1,
    input  write2, write_index2, write_data2,
    input  reserve, reserve_index,
    output read_value1, read_value2,
    output busy1, busy2, busy_mask, collision
  );

endinterface

// File: rtl/reg_file_multiport_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Per-register busy bits. A reserve marks a register as awaiting a
//   producer, a write from either port retires it.
//   clock          : state updates on the falling edge
//   clear          : asynchronous, active-high; clears every busy bit
//   reserve/_index : mark one register busy
//   write1/2, write_index1/2 : write-back ports that retire busy registers
//   busy_mask      : current busy bit of every register
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int DEPTH    = reg_file_multiport_pkg::DEPTH,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     reserve,
  input  logic [$clog2(DEPTH)-1:0] reserve_index,
  input  logic                     write1,
  input  logic [$clog2(DEPTH)-1:0] write_index1,
  input  logic                     write2,
  input  logic [$clog2(DEPTH)-1:0] write_index2,
  output logic [DEPTH-1:0]         busy_mask
);
  import reg_file_multiport_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // The reserve is applied after the write-back so that a new producer
  // claiming a register in the same cycle its old producer retires wins.
  // With a hardwired zero register, index 0 can never become busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((write1 && (write_index1 == AW'(i))) ||
          (write2 && (write_index2 == AW'(i)))) begin
        busy_d[i] = 1'b0;
      end
      if (reserve && (reserve_index == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/reg_file_multiport.sv
// ---------------------------------------------------------------------------
// reg_file_multiport
//   Register file with two combinational read ports, two prioritised write
//   ports (port 1 wins), optional hardwired zero register, optional
//   write-to-read bypass, a busy scoreboard and a sticky collision flag.
//   clock : all state updates on the falling edge
//   clear : asynchronous, active-high reset of registers, busy bits, collision
//   bus   : slave side of reg_file_multiport_if (reads, writes, reserve,
//           busy1/busy2/busy_mask, collision)
// ---------------------------------------------------------------------------
module reg_file_multiport #(
  parameter int DATA_WIDTH = reg_file_multiport_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_multiport_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                 clock,
  input  logic                 clear,
  reg_file_multiport_if.slave  bus
);
  import reg_file_multiport_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  collision_q;
  logic                  collision_d;
  logic [DEPTH-1:0]      busy_mask;
  logic                  bypass_en;
  logic                  drop_write1;
  logic                  drop_write2;
  read_src_t             src1;
  read_src_t             src2;

  function automatic logic [DATA_WIDTH-1:0] pick(input read_src_t             src,
                                                 input logic [DATA_WIDTH-1:0] stored,
                                                 input logic [DATA_WIDTH-1:0] wd1,
                                                 input logic [DATA_WIDTH-1:0] wd2);
    logic [DATA_WIDTH-1:0] value;
    case (src)
      SRC_ZERO:   value = '0;
      SRC_WRITE1: value = wd1;
      SRC_WRITE2: value = wd2;
      default:    value = stored;
    endcase
    return value;
  endfunction

  // While clear is held the pending writes are going to be discarded, so
  // forwarding them would show data that never lands in the file.
  assign bypass_en   = (BYPASS != 0) && !clear;
  assign drop_write1 = (ZERO_REG != 0) && (bus.write_index1 == '0);
  assign drop_write2 = (ZERO_REG != 0) && (bus.write_index2 == '0);

  // Port 2 is applied before port 1 so a shared index ends up with port 1's
  // data; index 0 is never written when it is hardwired.
  always_comb begin
    regs_d = regs_q;
    if (bus.write2 && !drop_write2) begin
      regs_d[bus.write_index2] = bus.write_data2;
    end
    if (bus.write1 && !drop_write1) begin
      regs_d[bus.write_index1] = bus.write_data1;
    end
  end

  // The collision is flagged even on index 0, because it reports a
  // write-back conflict regardless of whether the data is kept.
  always_comb begin
    collision_d = collision_q;
    if (bus.write1 && bus.write2 && (bus.write_index1 == bus.write_index2)) begin
      collision_d = 1'b1;
    end
  end

  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      regs_q      <= '{default: '0};
      collision_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      collision_q <= collision_d;
    end
  end

  // Each read port resolves its source first, then selects the data.
  always_comb begin
    src1 = read_mux((ZERO_REG != 0) && (bus.read_index1 == '0),
                    bypass_en && bus.write1 && (bus.read_index1 == bus.write_index1),
                    bypass_en && bus.write2 && (bus.read_index1 == bus.write_index2));
    src2 = read_mux((ZERO_REG != 0) && (bus.read_index2 == '0),
                    bypass_en && bus.write1 && (bus.read_index2 == bus.write_index1),
                    bypass_en && bus.write2 && (bus.read_index2 == bus.write_index2));
    bus.read_value1 = pick(src1, regs_q[bus.read_index1], bus.write_data1, bus.write_data2);
    bus.read_value2 = pick(src2, regs_q[bus.read_index2], bus.write_data1, bus.write_data2);
  end

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock         (clock),
    .clear         (clear),
    .reserve       (bus.reserve),
    .reserve_index (bus.reserve_index),
    .write1        (bus.write1),
    .write_index1  (bus.write_index1),
    .write2        (bus.write2),
    .write_index2  (bus.write_index2),
    .busy_mask     (busy_mask)
  );

  // Busy bits reflect the registered scoreboard only; a write-back in the
  // current cycle does not clear them until the edge.
  assign bus.busy_mask = busy_mask;
  assign bus.busy1     = busy_mask[bus.read_index1];
  assign bus.busy2     = busy_mask[bus.read_index2];
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_reg_file_multiport.sv
// ---------------------------------------------------------------------------
// tb_reg_file_multiport
//   Drives two register files (bypass on / bypass off) with identical
//   directed vectors. Expected values are queued as stimulus is issued and
//   compared by a separate monitor on the rising edge, mid-way between the
//   falling edges that update state.
// ---------------------------------------------------------------------------
module tb_reg_file_multiport;
  import reg_file_multiport_pkg::*;

  typedef struct {
    logic             clr;
    logic             w1;
    reg_index_t       wi1;
    logic [31:0]      wd1;
    logic             w2;
    reg_index_t       wi2;
    logic [31:0]      wd2;
    logic             rsv;
    reg_index_t       rsvi;
    reg_index_t       ri1;
    reg_index_t       ri2;
  } stim_t;

  typedef enum {RV1_A, RV2_A, RV1_B, RV2_B, BUSY1_A, BUSY2_A, MASK_A, COLL_A, COLL_B} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  logic clock;
  logic clear;
  int   checks;
  int   passes;
  exp_t exp_q[$];

  reg_file_multiport_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
  reg_file_multiport_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();

  reg_file_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clock (clock),
    .clear (clear),
    .bus   (bus_a.slave)
  );

  reg_file_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clock (clock),
    .clear (clear),
    .bus   (bus_b.slave)
  );

  // The no-bypass instance sees exactly the same inputs.
  assign bus_b.read_index1   = bus_a.read_index1;
  assign bus_b.read_index2   = bus_a.read_index2;
  assign bus_b.write1        = bus_a.write1;
  assign bus_b.write_index1  = bus_a.write_index1;
  assign bus_b.write_data1   = bus_a.write_data1;
  assign bus_b.write2        = bus_a.write2;
  assign bus_b.write_index2  = bus_a.write_index2;
  assign bus_b.write_data2   = bus_a.write_data2;
  assign bus_b.reserve       = bus_a.reserve;
  assign bus_b.reserve_index = bus_a.reserve_index;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic stim_t idle(input reg_index_t r1, input reg_index_t r2);
    stim_t s;
    s.clr  = 1'b0;
    s.w1   = 1'b0;
    s.wi1  = '0;
    s.wd1  = '0;
    s.w2   = 1'b0;
    s.wi2  = '0;
    s.wd2  = '0;
    s.rsv  = 1'b0;
    s.rsvi = '0;
    s.ri1  = r1;
    s.ri2  = r2;
    return s;
  endfunction

  function automatic logic [31:0] observe(input sel_e sel);
    logic [31:0] v;
    case (sel)
      RV1_A:   v = bus_a.read_value1;
      RV2_A:   v = bus_a.read_value2;
      RV1_B:   v = bus_b.read_value1;
      RV2_B:   v = bus_b.read_value2;
      BUSY1_A: v = {31'd0, bus_a.busy1};
      BUSY2_A: v = {31'd0, bus_a.busy2};
      MASK_A:  v = bus_a.busy_mask;
      COLL_A:  v = {31'd0, bus_a.collision};
      default: v = {31'd0, bus_b.collision};
    endcase
    return v;
  endfunction

  // Inputs change just after a falling edge so they are stable for the
  // monitor on the following rising edge and for the next state update.
  task automatic applyStimulus(input stim_t s);
    @(negedge clock);
    #1;
    clear               = s.clr;
    bus_a.write1        = s.w1;
    bus_a.write_index1  = s.wi1;
    bus_a.write_data1   = s.wd1;
    bus_a.write2        = s.w2;
    bus_a.write_index2  = s.wi2;
    bus_a.write_data2   = s.wd2;
    bus_a.reserve       = s.rsv;
    bus_a.reserve_index = s.rsvi;
    bus_a.read_index1   = s.ri1;
    bus_a.read_index2   = s.ri2;
  endtask

  task automatic checkOutput(input string name, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge drains whatever expectations are pending.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(posedge clock);
      while (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = observe(e.sel);
        checks++;
        if (act !== e.exp) begin
          $display("[TB] FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
        end else begin
          passes++;
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    checks = 0;
    passes = 0;

    // Reset pulse with all inputs idle; outputs are zero while clear is held.
    clear               = 1'b1;
    bus_a.write1        = 1'b0;
    bus_a.write_index1  = '0;
    bus_a.write_data1   = '0;
    bus_a.write2        = 1'b0;
    bus_a.write_index2  = '0;
    bus_a.write_data2   = '0;
    bus_a.reserve       = 1'b0;
    bus_a.reserve_index = '0;
    bus_a.read_index1   = 5'd1;
    bus_a.read_index2   = 5'd2;
    #2;
    checkOutput("reset_rv1", RV1_A, 32'd0);
    checkOutput("reset_mask", MASK_A, 32'd0);
    checkOutput("reset_coll", COLL_A, 32'd0);
    checkOutput("reset_busy1", BUSY1_A, 32'd0);

    // Sweep every index after reset.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(idle(reg_index_t'(2 * k), reg_index_t'(2 * k + 1)));
      checkOutput("sweep_rv1", RV1_A, 32'd0);
      checkOutput("sweep_rv2", RV2_A, 32'd0);
      checkOutput("sweep_rv1_nobypass", RV1_B, 32'd0);
    end
    checkOutput("sweep_mask", MASK_A, 32'd0);
    checkOutput("sweep_coll", COLL_A, 32'd0);

    // Bypass versus registered visibility.
    s = idle(5'd1, 5'd0); s.w1 = 1'b1; s.wi1 = 5'd1; s.wd1 = 32'd25;
    applyStimulus(s);
    checkOutput("bypass_before_edge", RV1_A, 32'd25);
    checkOutput("nobypass_before_edge", RV1_B, 32'd0);
    applyStimulus(idle(5'd1, 5'd0));
    checkOutput("bypass_after_edge", RV1_A, 32'd25);
    checkOutput("nobypass_after_edge", RV1_B, 32'd25);

    // Write collision on index 4: port 1 wins and collision sticks.
    s = idle(5'd4, 5'd4);
    s.w1 = 1'b1; s.wi1 = 5'd4; s.wd1 = 32'd3739;
    s.w2 = 1'b1; s.wi2 = 5'd4; s.wd2 = 32'd4295;
    applyStimulus(s);
    checkOutput("coll_bypass_rv1", RV1_A, 32'd3739);
    checkOutput("coll_bypass_rv2", RV2_A, 32'd3739);
    checkOutput("coll_before_edge", COLL_A, 32'd0);
    checkOutput("coll_nobypass_old", RV1_B, 32'd0);
    applyStimulus(idle(5'd4, 5'd4));
    checkOutput("coll_reg4_a", RV1_A, 32'd3739);
    checkOutput("coll_reg4_b", RV2_B, 32'd3739);
    checkOutput("coll_set_a", COLL_A, 32'd1);
    checkOutput("coll_set_b", COLL_B, 32'd1);
    s = idle(5'd4, 5'd0); s.w2 = 1'b1; s.wi2 = 5'd5; s.wd2 = 32'd1;
    applyStimulus(s);
    checkOutput("coll_sticky1", COLL_A, 32'd1);
    applyStimulus(idle(5'd5, 5'd0));
    checkOutput("coll_sticky2", COLL_A, 32'd1);
    checkOutput("reg5_written", RV1_B, 32'd1);

    // Reserve, then retire with a later write.
    s = idle(5'd7, 5'd0); s.rsv = 1'b1; s.rsvi = 5'd7;
    applyStimulus(s);
    checkOutput("busy7_before_reserve", BUSY1_A, 32'd0);
    s = idle(5'd7, 5'd0); s.w2 = 1'b1; s.wi2 = 5'd7; s.wd2 = 32'd625;
    applyStimulus(s);
    checkOutput("busy7_reserved", BUSY1_A, 32'd1);
    checkOutput("mask_reserved", MASK_A, 32'h0000_0080);
    checkOutput("wr2_bypass", RV1_A, 32'd625);
    checkOutput("wr2_nobypass", RV1_B, 32'd0);
    // Reserve and write on the same index in the same cycle.
    s = idle(5'd7, 5'd0);
    s.rsv = 1'b1; s.rsvi = 5'd7;
    s.w2 = 1'b1; s.wi2 = 5'd7; s.wd2 = 32'd625;
    applyStimulus(s);
    checkOutput("mask_retired", MASK_A, 32'd0);
    checkOutput("busy7_retired", BUSY1_A, 32'd0);
    checkOutput("reg7_stored", RV1_B, 32'd625);
    applyStimulus(idle(5'd7, 5'd0));
    checkOutput("mask_reserve_wins", MASK_A, 32'h0000_0080);
    checkOutput("reg7_after_both_b", RV1_B, 32'd625);
    checkOutput("reg7_after_both_a", RV1_A, 32'd625);

    // Hardwired zero register ignores writes, reserves and bypass.
    s = idle(5'd0, 5'd7);
    s.w1 = 1'b1; s.wi1 = 5'd0; s.wd1 = 32'd99;
    s.rsv = 1'b1; s.rsvi = 5'd0;
    applyStimulus(s);
    checkOutput("zero_no_bypass", RV1_A, 32'd0);
    checkOutput("zero_b_before", RV1_B, 32'd0);
    applyStimulus(idle(5'd0, 5'd7));
    checkOutput("zero_after_a", RV1_A, 32'd0);
    checkOutput("zero_after_b", RV1_B, 32'd0);
    checkOutput("zero_mask", MASK_A, 32'h0000_0080);
    checkOutput("zero_busy1", BUSY1_A, 32'd0);
    checkOutput("busy2_reg7", BUSY2_A, 32'd1);

    // Load busy state on registers 1 and 7, then clear mid-cycle.
    s = idle(5'd1, 5'd7); s.rsv = 1'b1; s.rsvi = 5'd1;
    applyStimulus(s);
    checkOutput("reg1_value", RV1_A, 32'd25);
    checkOutput("busy1_pre_reserve", BUSY1_A, 32'd0);
    applyStimulus(idle(5'd1, 5'd7));
    checkOutput("mask_1_7", MASK_A, 32'h0000_0082);
    checkOutput("busy1_set", BUSY1_A, 32'd1);
    checkOutput("busy2_set", BUSY2_A, 32'd1);
    checkOutput("reg7_pre_clear", RV2_A, 32'd625);
    checkOutput("coll_pre_clear", COLL_A, 32'd1);
    applyStimulus(idle(5'd1, 5'd7));
    #1;
    clear = 1'b1;
    checkOutput("async_rv1", RV1_A, 32'd0);
    checkOutput("async_rv2", RV2_A, 32'd0);
    checkOutput("async_mask", MASK_A, 32'd0);
    checkOutput("async_busy1", BUSY1_A, 32'd0);
    checkOutput("async_busy2", BUSY2_A, 32'd0);
    checkOutput("async_coll_a", COLL_A, 32'd0);
    checkOutput("async_coll_b", COLL_B, 32'd0);
    // A write presented while clear is held is neither forwarded nor stored.
    s = idle(5'd1, 5'd7); s.clr = 1'b1; s.w1 = 1'b1; s.wi1 = 5'd1; s.wd1 = 32'd55;
    applyStimulus(s);
    checkOutput("clear_no_bypass", RV1_A, 32'd0);
    checkOutput("clear_no_bypass_b", RV1_B, 32'd0);
    s = idle(5'd2, 5'd1); s.w1 = 1'b1; s.wi1 = 5'd2; s.wd1 = 32'h1234;
    applyStimulus(s);
    checkOutput("release_bypass", RV1_A, 32'h1234);
    checkOutput("release_nobypass", RV1_B, 32'd0);
    checkOutput("held_write_dropped", RV2_A, 32'd0);
    applyStimulus(idle(5'd2, 5'd1));
    checkOutput("release_store_a", RV1_A, 32'h1234);
    checkOutput("release_store_b", RV1_B, 32'h1234);
    checkOutput("reg1_still_zero", RV2_B, 32'd0);
    checkOutput("coll_after_release", COLL_A, 32'd0);

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
